mult_issue_ctrl: RTL and testbench

- Scheduler and arbiter for the dual pipelined multiplier pair (units 0 and 1).
- Steers up to two reservation-station multiply requests per cycle onto the two units and tracks in-flight occupancy per unit.
- Arbitrates the single multiplier CDB slot between the two units, stalling the loser.
- Squashes all in-flight work on a pipeline flush.

---
 rtl/mult_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_issue_ctrl
// Purpose  : Issue scheduler and CDB arbiter for a pair of pipelined
//            multipliers (unit 0 and unit 1). Steers up to two RS requests
//            per cycle onto the units, tracks in-flight occupancy per unit,
//            arbitrates the single multiplier CDB slot (round-robin on a
//            collision) and squashes in-flight work on a flush.
// Ports    : clock, reset (async, active-high), flush
//            req0/1_valid -> req0/1_gnt, req0/1_unit, start0/1
//            mult0/1_done, mult0/1_ROB, mult0/1_PRN -> mult0/1_stall
//            cdb_free -> cdb_valid, cdb_sel, cdb_ROB, cdb_PRN (registered)
// Revision : 1.0 - initial release
// ============================================================================
module mult_issue_ctrl #(
   parameter int ROB_BITS = 6,
   parameter int PRN_BITS = 7,
   parameter int DEPTH    = 8,
   parameter int CNT_BITS = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                req0_valid,
   input  logic                req1_valid,
   output logic                req0_gnt,
   output logic                req1_gnt,
   output logic                req0_unit,
   output logic                req1_unit,
   output logic                start0,
   output logic                start1,
   input  logic                mult0_done,
   input  logic                mult1_done,
   input  logic [ROB_BITS-1:0] mult0_ROB,
   input  logic [ROB_BITS-1:0] mult1_ROB,
   input  logic [PRN_BITS-1:0] mult0_PRN,
   input  logic [PRN_BITS-1:0] mult1_PRN,
   output logic                mult0_stall,
   output logic                mult1_stall,
   input  logic                cdb_free,
   output logic                cdb_valid,
   output logic                cdb_sel,
   output logic [ROB_BITS-1:0] cdb_ROB,
   output logic [PRN_BITS-1:0] cdb_PRN
);

   localparam logic [CNT_BITS-1:0] c_depth = CNT_BITS'(DEPTH);
   localparam logic [CNT_BITS-1:0] c_zero  = '0;

   logic [CNT_BITS-1:0] occ0_q, occ0_d, occ1_q, occ1_d;
   logic [CNT_BITS-1:0] drop0_q, drop0_d, drop1_q, drop1_d;
   logic                rr_q, rr_d;
   logic                cdb_valid_q, cdb_valid_d;
   logic                cdb_sel_q, cdb_sel_d;
   logic [ROB_BITS-1:0] cdb_rob_q, cdb_rob_d;
   logic [PRN_BITS-1:0] cdb_prn_q, cdb_prn_d;

   logic w_drop0, w_drop1;
   logic w_elig0, w_elig1;
   logic w_win0, w_win1;
   logic w_avail0, w_avail1;
   logic w_s0_u0, w_s0_u1;

   // ---------------------------------------------------------------------
   // Completion arbitration. A done pulse that belongs to a squashed op
   // (drop counter non-zero) is consumed silently: it neither competes for
   // the CDB nor stalls its pipeline. Stalls are forced low during reset so
   // the pipelines are released as soon as reset asserts.
   // ---------------------------------------------------------------------
   always_comb begin
      w_drop0     = mult0_done & (drop0_q != c_zero);
      w_drop1     = mult1_done & (drop1_q != c_zero);
      w_elig0     = mult0_done & ~w_drop0 & cdb_free & ~flush & ~reset;
      w_elig1     = mult1_done & ~w_drop1 & cdb_free & ~flush & ~reset;
      w_win0      = w_elig0 & (~w_elig1 | ~rr_q);
      w_win1      = w_elig1 & (~w_elig0 |  rr_q);
      mult0_stall = mult0_done & ~w_win0 & ~w_drop0 & ~reset;
      mult1_stall = mult1_done & ~w_win1 & ~w_drop1 & ~reset;
   end

   // ---------------------------------------------------------------------
   // Issue steering. A unit completing this cycle still counts as occupied;
   // its slot frees only on the following cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      w_avail0  = ~mult0_stall & (occ0_q < c_depth) & ~flush & ~reset;
      w_avail1  = ~mult1_stall & (occ1_q < c_depth) & ~flush & ~reset;
      req0_gnt  = 1'b0;
      req0_unit = 1'b0;
      req1_gnt  = 1'b0;
      req1_unit = 1'b0;
      if (req0_valid) begin
         if (w_avail0) begin
            req0_gnt = 1'b1;
         end else if (w_avail1) begin
            req0_gnt  = 1'b1;
            req0_unit = 1'b1;
         end
      end
      w_s0_u0 = req0_gnt & ~req0_unit;
      w_s0_u1 = req0_gnt &  req0_unit;
      if (req1_valid) begin
         if (w_avail1 & ~w_s0_u1) begin
            req1_gnt  = 1'b1;
            req1_unit = 1'b1;
         end else if (w_avail0 & ~w_s0_u0) begin
            req1_gnt = 1'b1;
         end
      end
      start0 = w_s0_u0 | (req1_gnt & ~req1_unit);
      start1 = w_s0_u1 | (req1_gnt &  req1_unit);
   end

   // ---------------------------------------------------------------------
   // Next-state: occupancy, drop counters, round-robin pointer, CDB regs.
   // On flush every in-flight op becomes a squashed op to be dropped; any
   // drops still outstanding from an earlier flush are kept.
   // ---------------------------------------------------------------------
   always_comb begin
      occ0_d  = occ0_q + CNT_BITS'(start0) - CNT_BITS'(w_win0);
      occ1_d  = occ1_q + CNT_BITS'(start1) - CNT_BITS'(w_win1);
      drop0_d = drop0_q - CNT_BITS'(w_drop0);
      drop1_d = drop1_q - CNT_BITS'(w_drop1);
      if (flush) begin
         occ0_d  = c_zero;
         occ1_d  = c_zero;
         drop0_d = drop0_d + occ0_q;
         drop1_d = drop1_d + occ1_q;
      end
      rr_d        = rr_q ^ (w_elig0 & w_elig1);
      cdb_valid_d = (w_win0 | w_win1) & ~flush;
      cdb_sel_d   = cdb_sel_q;
      cdb_rob_d   = cdb_rob_q;
      cdb_prn_d   = cdb_prn_q;
      if (w_win1) begin
         cdb_sel_d = 1'b1;
         cdb_rob_d = mult1_ROB;
         cdb_prn_d = mult1_PRN;
      end else if (w_win0) begin
         cdb_sel_d = 1'b0;
         cdb_rob_d = mult0_ROB;
         cdb_prn_d = mult0_PRN;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occ0_q      <= '0;
         occ1_q      <= '0;
         drop0_q     <= '0;
         drop1_q     <= '0;
         rr_q        <= 1'b0;
         cdb_valid_q <= 1'b0;
         cdb_sel_q   <= 1'b0;
         cdb_rob_q   <= '0;
         cdb_prn_q   <= '0;
      end else begin
         occ0_q      <= occ0_d;
         occ1_q      <= occ1_d;
         drop0_q     <= drop0_d;
         drop1_q     <= drop1_d;
         rr_q        <= rr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_sel_q   <= cdb_sel_d;
         cdb_rob_q   <= cdb_rob_d;
         cdb_prn_q   <= cdb_prn_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_sel   = cdb_sel_q;
   assign cdb_ROB   = cdb_rob_q;
   assign cdb_PRN   = cdb_prn_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_issue_ctrl
// Purpose  : Directed self-checking bench for mult_issue_ctrl. Expected CDB
//            broadcasts are queued by the stimulus and popped by a monitor
//            whenever cdb_valid is seen; issue/stall outputs are checked
//            inline against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_issue_ctrl;

   localparam int ROB_BITS = 6;
   localparam int PRN_BITS = 7;
   localparam int DEPTH    = 8;
   localparam int CNT_BITS = 4;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                flush = 1'b0;
   logic                req0_valid = 1'b0, req1_valid = 1'b0;
   logic                req0_gnt, req1_gnt, req0_unit, req1_unit, start0, start1;
   logic                mult0_done = 1'b0, mult1_done = 1'b0;
   logic [ROB_BITS-1:0] mult0_ROB = '0, mult1_ROB = '0;
   logic [PRN_BITS-1:0] mult0_PRN = '0, mult1_PRN = '0;
   logic                mult0_stall, mult1_stall;
   logic                cdb_free = 1'b0;
   logic                cdb_valid, cdb_sel;
   logic [ROB_BITS-1:0] cdb_ROB;
   logic [PRN_BITS-1:0] cdb_PRN;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic                sel;
      logic [ROB_BITS-1:0] rob;
      logic [PRN_BITS-1:0] prn;
   } cdb_t;
   cdb_t sb_q[$];

   mult_issue_ctrl #(
      .ROB_BITS(ROB_BITS), .PRN_BITS(PRN_BITS), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_gnt(req0_gnt), .req1_gnt(req1_gnt),
      .req0_unit(req0_unit), .req1_unit(req1_unit),
      .start0(start0), .start1(start1),
      .mult0_done(mult0_done), .mult1_done(mult1_done),
      .mult0_ROB(mult0_ROB), .mult1_ROB(mult1_ROB),
      .mult0_PRN(mult0_PRN), .mult1_PRN(mult1_PRN),
      .mult0_stall(mult0_stall), .mult1_stall(mult1_stall),
      .cdb_free(cdb_free), .cdb_valid(cdb_valid), .cdb_sel(cdb_sel),
      .cdb_ROB(cdb_ROB), .cdb_PRN(cdb_PRN)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_issue(input logic g0, input logic u0, input logic g1,
                            input logic u1, input logic s0, input logic s1);
      chk("req0_gnt", {31'd0, req0_gnt}, {31'd0, g0});
      chk("req0_unit", {31'd0, req0_unit}, {31'd0, u0});
      chk("req1_gnt", {31'd0, req1_gnt}, {31'd0, g1});
      chk("req1_unit", {31'd0, req1_unit}, {31'd0, u1});
      chk("start0", {31'd0, start0}, {31'd0, s0});
      chk("start1", {31'd0, start1}, {31'd0, s1});
   endtask

   task automatic chk_stall(input logic s0, input logic s1);
      chk("mult0_stall", {31'd0, mult0_stall}, {31'd0, s0});
      chk("mult1_stall", {31'd0, mult1_stall}, {31'd0, s1});
   endtask

   task automatic expect_cdb(input logic sel, input int rob, input int prn);
      sb_q.push_back({sel, ROB_BITS'(rob), PRN_BITS'(prn)});
   endtask

   task automatic quiet();
      req0_valid = 1'b0; req1_valid = 1'b0;
      mult0_done = 1'b0; mult1_done = 1'b0;
      cdb_free   = 1'b0; flush      = 1'b0;
   endtask

   // Monitor: every broadcast must match the oldest queued expectation.
   always @(negedge clock) begin
      if (!reset && cdb_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL cdb_unexpected: got sel=%0d ROB=%0d PRN=%0d with nothing expected",
                     cdb_sel, cdb_ROB, cdb_PRN);
         end else begin
            cdb_t e;
            e = sb_q.pop_front();
            if ({cdb_sel, cdb_ROB, cdb_PRN} !== e) begin
               errors++;
               $display("FAIL cdb_data: got sel=%0d ROB=%0d PRN=%0d expected sel=%0d ROB=%0d PRN=%0d",
                        cdb_sel, cdb_ROB, cdb_PRN, e.sel, e.rob, e.prn);
            end
         end
      end
   end

   // Occupancy must never wrap below zero (or exceed DEPTH).
   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (dut.occ0_q > CNT_BITS'(DEPTH) || dut.occ1_q > CNT_BITS'(DEPTH)) begin
            errors++;
            $display("FAIL occ_range: got occ0=%0d occ1=%0d required <= %0d",
                     dut.occ0_q, dut.occ1_q, DEPTH);
         end
      end
   end

   initial begin
      // ---------------- reset state ----------------
      repeat (2) @(posedge clock);
      #1;
      chk_issue(0, 0, 0, 0, 0, 0);
      chk_stall(0, 0);
      chk("rst_cdb_valid", {31'd0, cdb_valid}, 0);
      chk("rst_cdb_tags", {18'd0, cdb_sel, cdb_ROB, cdb_PRN}, 0);
      chk("rst_occ0", 32'(dut.occ0_q), 0);
      reset = 1'b0;

      // ---------------- single issue + completion ----------------
      tick(); req0_valid = 1'b1;
      #2; chk_issue(1, 0, 0, 0, 1, 0);
      tick(); req0_valid = 1'b0;
      mult0_done = 1'b1; mult0_ROB = 6'd5; mult0_PRN = 7'd17; cdb_free = 1'b1;
      expect_cdb(0, 5, 17);
      #2; chk_stall(0, 0);
      tick(); quiet();
      #2; chk("single_cdb_valid", {31'd0, cdb_valid}, 1);
      chk("single_occ0", 32'(dut.occ0_q), 0);

      // ---------------- dual issue + collisions ----------------
      tick(); req0_valid = 1'b1; req1_valid = 1'b1;
      #2; chk_issue(1, 0, 1, 1, 1, 1);
      tick(); quiet(); cdb_free = 1'b1;
      mult0_done = 1'b1; mult0_ROB = 6'd10; mult0_PRN = 7'd20;
      mult1_done = 1'b1; mult1_ROB = 6'd11; mult1_PRN = 7'd21;
      expect_cdb(0, 10, 20);
      #2; chk_stall(0, 1);
      tick(); mult0_done = 1'b0;
      expect_cdb(1, 11, 21);
      #2; chk_stall(0, 0);
      tick(); quiet(); req0_valid = 1'b1; req1_valid = 1'b1;
      #2; chk_issue(1, 0, 1, 1, 1, 1);
      tick(); quiet(); cdb_free = 1'b1;
      mult0_done = 1'b1; mult0_ROB = 6'd12; mult0_PRN = 7'd22;
      mult1_done = 1'b1; mult1_ROB = 6'd13; mult1_PRN = 7'd23;
      expect_cdb(1, 13, 23);
      #2; chk_stall(1, 0);
      tick(); mult1_done = 1'b0;
      expect_cdb(0, 12, 22);
      #2; chk_stall(0, 0);

      // ---------------- CDB blocked for three cycles ----------------
      tick(); quiet(); req0_valid = 1'b1;
      #2; chk_issue(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); quiet();
         mult0_done = 1'b1; mult0_ROB = 6'd33; mult0_PRN = 7'd99;
         #2; chk_stall(1, 0);
         chk("blocked_cdb_valid", {31'd0, cdb_valid}, 0);
      end
      tick(); cdb_free = 1'b1;
      expect_cdb(0, 33, 99);
      #2; chk_stall(0, 0);
      tick(); quiet();
      #2; chk("blocked_cdb_valid_after", {31'd0, cdb_valid}, 1);

      // ---------------- occupancy full ----------------
      for (int i = 0; i < DEPTH; i++) begin
         tick(); quiet(); req0_valid = 1'b1;
         #2; chk_issue(1, 0, 0, 0, 1, 0);
      end
      tick();
      #2; chk_issue(1, 1, 0, 0, 0, 1);
      tick(); mult1_done = 1'b1; mult1_ROB = 6'd40; mult1_PRN = 7'd41;
      #2; chk_issue(0, 0, 0, 0, 0, 0);
      chk_stall(0, 1);
      // Unit 0 completes while full: its slot must not free this cycle.
      tick(); cdb_free = 1'b1;
      mult0_done = 1'b1; mult0_ROB = 6'd1; mult0_PRN = 7'd2;
      expect_cdb(0, 1, 2);
      #2; chk_issue(0, 0, 0, 0, 0, 0);
      chk_stall(0, 1);
      tick(); req0_valid = 1'b0;
      mult0_ROB = 6'd2; mult0_PRN = 7'd3;
      expect_cdb(1, 40, 41);
      #2; chk_stall(1, 0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         tick(); mult1_done = 1'b0;
         mult0_done = 1'b1; mult0_ROB = ROB_BITS'(2 + i); mult0_PRN = PRN_BITS'(3 + i);
         expect_cdb(0, 2 + i, 3 + i);
         #2; chk_stall(0, 0);
      end
      tick(); quiet();
      #2; chk("full_occ0", 32'(dut.occ0_q), 0);
      chk("full_occ1", 32'(dut.occ1_q), 0);

      // ---------------- flush with three in flight ----------------
      for (int i = 0; i < 3; i++) begin
         tick(); quiet(); req0_valid = 1'b1;
         #2; chk_issue(1, 0, 0, 0, 1, 0);
      end
      tick(); flush = 1'b1;
      #2; chk_issue(0, 0, 0, 0, 0, 0);
      tick(); quiet();
      #2; chk("flush_occ0", 32'(dut.occ0_q), 0);
      for (int i = 0; i < 4; i++) begin
         tick(); quiet(); cdb_free = 1'b1;
         mult0_done = (i != 1);
         mult0_ROB = 6'd60; mult0_PRN = 7'd61;
         #2; chk_stall(0, 0);
         chk("flush_cdb_valid", {31'd0, cdb_valid}, 0);
      end
      tick(); quiet(); req0_valid = 1'b1;
      #2; chk_issue(1, 0, 0, 0, 1, 0);
      chk("flush_drop_cdb_valid", {31'd0, cdb_valid}, 0);
      tick(); quiet(); cdb_free = 1'b1;
      mult0_done = 1'b1; mult0_ROB = 6'd50; mult0_PRN = 7'd60;
      expect_cdb(0, 50, 60);
      #2; chk_stall(0, 0);
      tick(); quiet();
      #2; chk("reissue_cdb_valid", {31'd0, cdb_valid}, 1);

      // ---------------- async reset during a stall ----------------
      tick(); req0_valid = 1'b1; req1_valid = 1'b1;
      #2; chk_issue(1, 0, 1, 1, 1, 1);
      tick(); quiet(); cdb_free = 1'b1;
      mult1_done = 1'b1; mult1_ROB = 6'd7; mult1_PRN = 7'd8;
      tick(); quiet();
      mult0_done = 1'b1; mult0_ROB = 6'd9; mult0_PRN = 7'd10;
      #1; chk("pre_rst_cdb_valid", {31'd0, cdb_valid}, 1);
      chk_stall(1, 0);
      #1; reset = 1'b1;
      #1; chk("async_cdb_valid", {31'd0, cdb_valid}, 0);
      chk_stall(0, 0);
      chk("async_occ0", 32'(dut.occ0_q), 0);
      chk("async_occ1", 32'(dut.occ1_q), 0);
      tick(); quiet();
      tick(); reset = 1'b0;
      tick();
      #2; chk_issue(0, 0, 0, 0, 0, 0);

      tick();
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
